led_pwm_bank: RTL and testbench
===============================

LED_PWM_BANK -- requirements
Module: led_pwm_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of LED outputs, 1..16.
REQ-002 SHALL have parameter PWM_BITS, default 8: width of duty and PWM counter.
REQ-003 SHALL have parameter PRESC_BITS, default 16: width of the shared prescaler.
REQ-004 SHALL have parameter INVERT, CHANNELS bits, default 0: per-channel output polarity, 1 = active-low LED.
REQ-005 SHALL have port clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-007 SHALL have port cfg_we, input, 1 bit: configuration write strobe, one write per asserted cycle.
REQ-008 SHALL have port cfg_ch, input, max(1,clog2(CHANNELS)) bits: target channel index.
REQ-009 SHALL have port cfg_mode, input, 3 bits: 0 OFF, 1 ON, 2 PWM, 3 BLINK, 4 BREATHE, 5-7 treated as OFF.
REQ-010 SHALL have port cfg_duty, input, PWM_BITS bits: duty, blink half-period or breathe peak.
REQ-011 SHALL have port led, output, CHANNELS bits: registered LED drives.
REQ-012 SHALL have port tick, output, 1 bit: registered one-cycle prescaler-wrap pulse.

Function
REQ-013 SHALL run free-running prescaler presc (PRESC_BITS) +1 per cycle, wrapping modulo 2^PRESC_BITS; tick SHALL be 1 in the cycle after presc holds all-ones.
REQ-014 SHALL run free-running pwm_cnt (PWM_BITS) +1 per cycle, wrapping modulo 2^PWM_BITS, shared by all channels.
REQ-015 SHALL hold per channel: mode, duty, blink counter bcnt, blink phase, breathe level, breathe direction dir (1 = up).
REQ-016 SHALL, on cfg_we with cfg_ch < CHANNELS, load mode and duty for that channel and clear bcnt, phase, level to 0 and set dir to 1.
REQ-017 SHALL ignore a write with cfg_ch >= CHANNELS, changing no state.
REQ-018 SHALL compute raw output: OFF 0; ON 1; PWM (pwm_cnt < duty); BLINK phase; BREATHE (pwm_cnt < level).
REQ-019 SHALL register led[i] = raw[i] XOR INVERT[i], so a write sampled at edge k is first visible on led at edge k+1 (one cycle of latency after the registered configuration).
REQ-020 SHALL give PWM duty 0 constant raw 0 and duty 2^PWM_BITS-1 raw 1 for all but one cycle per PWM period.
REQ-021 SHALL, in BLINK on each tick: if bcnt == duty then bcnt <= 0 and phase toggles, else bcnt +1; period = 2*(duty+1) ticks.
REQ-022 SHALL, in BREATHE on each tick: if dir=1 and level >= duty then dir <= 0, elif dir=1 then level +1; if dir=0 and level == 0 then dir <= 1, elif dir=0 then level -1.
REQ-023 SHALL, for BREATHE with duty 0, hold level 0 (raw 0) with dir toggling each tick.
REQ-024 SHALL, when a write and a tick coincide for the same channel, apply the write (state cleared) and discard that tick for that channel; other channels advance normally.
REQ-025 SHALL not advance bcnt/phase/level/dir in modes other than the one using them; they hold their values.
REQ-026 SHALL never overflow level or bcnt; both stay within 0..duty.

Reset
REQ-027 SHALL, while rst_n is 0 at a clock edge, set presc, pwm_cnt, tick to 0, every channel to mode OFF, duty 0, bcnt 0, phase 0, level 0, dir 1, and led to INVERT.
REQ-028 SHALL, with reset asserted mid-operation, discard all configuration and restart counters from 0; cfg_we is ignored while rst_n is 0.
REQ-029 SHALL resume counting on the first edge with rst_n = 1; first tick appears 2^PRESC_BITS cycles after reset release.

Verification (CHANNELS=3, PWM_BITS=4, PRESC_BITS=4, INVERT=3'b010)
REQ-030 SHALL cover reset: rst_n low 3 cycles -> led=3'b010, tick=0; release -> tick first high 16 cycles later, then every 16.
REQ-031 SHALL cover ON/PWM: write ch0 ON -> led[0]=1 two edges after write; write ch2 PWM duty=4 -> led[2] high exactly 4 of every 16 cycles; duty=0 -> led[2] constant 0.
REQ-032 SHALL cover BLINK: ch1 BLINK duty=1 -> led[1] (inverted) toggles every 2 ticks, 64-cycle period.
REQ-033 SHALL cover BREATHE: ch0 duty=3 -> level per tick 0,1,2,3,3,2,1,0,0,1 (turnaround holds one tick); led[0] high-time per PWM period tracks level.
REQ-034 SHALL cover boundaries: write cfg_ch=3 -> no state change; write ch1 in a tick cycle -> bcnt=0, phase=0, tick discarded.
REQ-035 SHALL cover mid-operation reset: rst_n low 1 cycle during BREATHE -> all outputs return to INVERT, modes OFF.

Source files
------------

// File: rtl/led_pwm_bank.sv
// led_pwm_bank -- bank of LED drivers sharing one prescaler and one PWM counter.
//
// Each channel is independently configured to OFF, ON, PWM (fixed duty),
// BLINK (square wave measured in prescaler ticks) or BREATHE (a triangle ramp
// of PWM level, one step per tick). Output polarity is set per channel at
// build time.
//
// Ports (led_pwm_bank):
//   clk       sole clock, rising edge
//   rst_n     synchronous active-low reset
//   cfg_we    configuration write strobe (one write per asserted cycle)
//   cfg_ch    target channel; out-of-range indices are ignored
//   cfg_mode  0 OFF, 1 ON, 2 PWM, 3 BLINK, 4 BREATHE, 5-7 OFF
//   cfg_duty  PWM duty / blink half-period-1 / breathe peak
//   led       registered LED drives (already polarity-adjusted)
//   tick      registered one-cycle pulse after the prescaler wraps
//
// Ports (led_pwm_ch, one per channel):
//   i_clk, i_rst_n        clock and synchronous active-low reset
//   i_we, i_mode, i_duty  channel-local write strobe and configuration
//   i_tick, i_pwm_cnt     shared timebase
//   o_led                 registered drive for this LED

module led_pwm_ch #(
    parameter int PWM_BITS = 8,
    parameter bit INV      = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_we,
    input  logic [2:0]          i_mode,
    input  logic [PWM_BITS-1:0] i_duty,
    input  logic                i_tick,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_led
);
    localparam logic [2:0] M_ON      = 3'd1;
    localparam logic [2:0] M_PWM     = 3'd2;
    localparam logic [2:0] M_BLINK   = 3'd3;
    localparam logic [2:0] M_BREATHE = 3'd4;

    logic [2:0]          r_mode;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] r_bcnt;
    logic [PWM_BITS-1:0] r_level;
    logic                r_phase;
    logic                r_dir;
    logic                r_led;
    logic                w_raw;

    always_comb begin
        w_raw = 1'b0;
        case (r_mode)
            M_ON:      w_raw = 1'b1;
            M_PWM:     w_raw = (i_pwm_cnt < r_duty);
            M_BLINK:   w_raw = r_phase;
            M_BREATHE: w_raw = (i_pwm_cnt < r_level);
            default:   w_raw = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mode  <= '0;
            r_duty  <= '0;
            r_bcnt  <= '0;
            r_level <= '0;
            r_phase <= 1'b0;
            r_dir   <= 1'b1;
            r_led   <= INV;
        end else begin
            r_led <= w_raw ^ INV;
            // A write wins over a coincident tick: the tick is simply dropped
            // for this channel so the fresh configuration starts from zero.
            if (i_we) begin
                r_mode  <= i_mode;
                r_duty  <= i_duty;
                r_bcnt  <= '0;
                r_level <= '0;
                r_phase <= 1'b0;
                r_dir   <= 1'b1;
            end else if (i_tick) begin
                if (r_mode == M_BLINK) begin
                    if (r_bcnt == r_duty) begin
                        r_bcnt  <= '0;
                        r_phase <= ~r_phase;
                    end else begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end else if (r_mode == M_BREATHE) begin
                    // Direction flips without moving the level, so the peak
                    // and the floor each hold for one extra tick.
                    if (r_dir) begin
                        if (r_level >= r_duty) r_dir   <= 1'b0;
                        else                   r_level <= r_level + 1'b1;
                    end else begin
                        if (r_level == '0) r_dir   <= 1'b1;
                        else               r_level <= r_level - 1'b1;
                    end
                end
            end
        end
    end

    assign o_led = r_led;
endmodule

module led_pwm_bank #(
    parameter int                 CHANNELS   = 3,
    parameter int                 PWM_BITS   = 8,
    parameter int                 PRESC_BITS = 16,
    parameter logic [CHANNELS-1:0] INVERT    = '0,
    localparam int                CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [2:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic [CHANNELS-1:0] led,
    output logic                tick
);
    logic [PRESC_BITS-1:0] r_presc;
    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic                  r_tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_presc   <= r_presc + 1'b1;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_tick    <= &r_presc;
        end
    end

    assign tick = r_tick;

    // Indices at or above CHANNELS never match any instance, so such writes
    // fall through without touching state.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        led_pwm_ch #(
            .PWM_BITS (PWM_BITS),
            .INV      (INVERT[i])
        ) u_ch (
            .i_clk     (clk),
            .i_rst_n   (rst_n),
            .i_we      (cfg_we && (cfg_ch == CH_W'(i))),
            .i_mode    (cfg_mode),
            .i_duty    (cfg_duty),
            .i_tick    (r_tick),
            .i_pwm_cnt (r_pwm_cnt),
            .o_led     (led[i])
        );
    end
endmodule

// File: tb/tb_led_pwm_bank.sv
// Testbench for led_pwm_bank (CHANNELS=3, PWM_BITS=4, PRESC_BITS=4, INVERT=3'b010).
module tb_led_pwm_bank;
    localparam logic [2:0] INV = 3'b010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [2:0] cfg_mode;
    logic [3:0] cfg_duty;
    logic [2:0] led;
    logic       tick;

    int n_chk = 0;
    int n_err = 0;

    // reference model state (plain integers, one entry per channel)
    logic [2:0] inv_v = INV;
    int  m_cyc = 0;
    bit  m_tick = 1'b0;
    bit [2:0] m_led = 3'b000;
    int  m_mode [3];
    int  m_duty [3];
    int  m_bcnt [3];
    int  m_phase[3];
    int  m_level[3];
    int  m_dir  [3];

    typedef struct {
        bit   rn;
        bit   we;
        int   ch;
        int   md;
        int   dt;
        logic [2:0] el;
        logic et;
    } vec_t;
    vec_t tbl[19];

    int exp_lv[9] = '{1, 2, 3, 3, 2, 1, 0, 0, 1};

    led_pwm_bank #(
        .CHANNELS   (3),
        .PWM_BITS   (4),
        .PRESC_BITS (4),
        .INVERT     (INV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_duty (cfg_duty),
        .led      (led),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the behavioural model: outputs after the edge are a
    // function of the state and counter value before it.
    task automatic model_edge(input bit rn, input bit we, input int ch, input int mode, input int duty);
        int pwm;
        bit tk;
        bit raw;
        pwm = m_cyc % 16;
        tk  = m_tick;
        if (!rn) begin
            m_cyc  = 0;
            m_tick = 1'b0;
            m_led  = inv_v;
            for (int i = 0; i < 3; i++) begin
                m_mode[i] = 0; m_duty[i] = 0; m_bcnt[i] = 0;
                m_phase[i] = 0; m_level[i] = 0; m_dir[i] = 1;
            end
            return;
        end
        for (int i = 0; i < 3; i++) begin
            case (m_mode[i])
                1:       raw = 1'b1;
                2:       raw = (pwm < m_duty[i]);
                3:       raw = (m_phase[i] != 0);
                4:       raw = (pwm < m_level[i]);
                default: raw = 1'b0;
            endcase
            m_led[i] = raw ^ inv_v[i];
        end
        for (int i = 0; i < 3; i++) begin
            if (we && ch == i) begin
                m_mode[i] = mode; m_duty[i] = duty; m_bcnt[i] = 0;
                m_phase[i] = 0; m_level[i] = 0; m_dir[i] = 1;
            end else if (tk && m_mode[i] == 3) begin
                if (m_bcnt[i] == m_duty[i]) begin
                    m_bcnt[i] = 0;
                    m_phase[i] = 1 - m_phase[i];
                end else begin
                    m_bcnt[i]++;
                end
            end else if (tk && m_mode[i] == 4) begin
                if (m_dir[i] == 1) begin
                    if (m_level[i] >= m_duty[i]) m_dir[i] = 0;
                    else m_level[i]++;
                end else begin
                    if (m_level[i] == 0) m_dir[i] = 1;
                    else m_level[i]--;
                end
            end
        end
        m_cyc++;
        m_tick = (m_cyc % 16 == 0);
    endtask

    task automatic step(input bit rn, input bit we, input int ch, input int mode, input int duty);
        rst_n    = rn;
        cfg_we   = we;
        cfg_ch   = 2'(ch);
        cfg_mode = 3'(mode);
        cfg_duty = 4'(duty);
        @(posedge clk);
        model_edge(rn, we, ch, mode, duty);
        #1;
        chk("model_led", {29'd0, led}, {29'd0, m_led});
        chk("model_tick", {31'd0, tick}, {31'd0, m_tick});
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 0, 0, 0);
    endtask

    initial begin
        int n;
        int sum;
        int nt;
        int tt[3];
        logic prev;

        // rn, we, ch, mode, duty, expected led, expected tick
        tbl[0]  = '{0, 0, 0, 0, 0, 3'b010, 1'b0};
        tbl[1]  = '{0, 1, 0, 1, 0, 3'b010, 1'b0};  // write during reset ignored
        tbl[2]  = '{0, 0, 0, 0, 0, 3'b010, 1'b0};
        tbl[3]  = '{1, 0, 0, 0, 0, 3'b010, 1'b0};
        tbl[4]  = '{1, 0, 0, 0, 0, 3'b010, 1'b0};
        tbl[5]  = '{1, 1, 0, 1, 0, 3'b010, 1'b0};  // ch0 ON
        tbl[6]  = '{1, 0, 0, 0, 0, 3'b011, 1'b0};
        tbl[7]  = '{1, 1, 1, 1, 0, 3'b011, 1'b0};  // ch1 ON (active-low)
        tbl[8]  = '{1, 0, 0, 0, 0, 3'b001, 1'b0};
        tbl[9]  = '{1, 1, 3, 1, 5, 3'b001, 1'b0};  // out-of-range channel
        tbl[10] = '{1, 0, 0, 0, 0, 3'b001, 1'b0};
        tbl[11] = '{1, 1, 2, 1, 0, 3'b001, 1'b0};  // ch2 ON
        tbl[12] = '{1, 0, 0, 0, 0, 3'b101, 1'b0};
        tbl[13] = '{1, 1, 2, 5, 0, 3'b101, 1'b0};  // mode 5 acts as OFF
        tbl[14] = '{1, 0, 0, 0, 0, 3'b001, 1'b0};
        tbl[15] = '{1, 1, 0, 0, 0, 3'b001, 1'b0};
        tbl[16] = '{1, 0, 0, 0, 0, 3'b000, 1'b0};
        tbl[17] = '{1, 1, 1, 0, 0, 3'b000, 1'b0};
        tbl[18] = '{1, 0, 0, 0, 0, 3'b010, 1'b1};  // 16th edge after release

        for (int v = 0; v < 19; v++) begin
            step(tbl[v].rn, tbl[v].we, tbl[v].ch, tbl[v].md, tbl[v].dt);
            chk($sformatf("tbl%0d_led", v), {29'd0, led}, {29'd0, tbl[v].el});
            chk($sformatf("tbl%0d_tick", v), {31'd0, tick}, {31'd0, tbl[v].et});
        end

        // tick timing after reset release
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 0, 0, 0);
        chk("reset_led", {29'd0, led}, 32'd2);
        n = 0;
        do begin idle(); n++; end while (tick !== 1'b1 && n < 40);
        chk("first_tick_cycles", n, 16);
        n = 0;
        do begin idle(); n++; end while (tick !== 1'b1 && n < 40);
        chk("tick_period", n, 16);

        // ON latency
        step(1'b1, 1'b1, 0, 1, 0);
        chk("on_edge_k", {31'd0, led[0]}, 32'd0);
        idle();
        chk("on_edge_k1", {31'd0, led[0]}, 32'd1);

        // PWM duty 4, 0, 15 on ch2
        step(1'b1, 1'b1, 2, 2, 4);
        idle();
        sum = 0;
        for (int k = 0; k < 16; k++) begin idle(); sum += int'(led[2]); end
        chk("pwm_duty4_high", sum, 4);
        step(1'b1, 1'b1, 2, 2, 0);
        idle();
        sum = 0;
        for (int k = 0; k < 32; k++) begin idle(); sum += int'(led[2]); end
        chk("pwm_duty0_high", sum, 0);
        step(1'b1, 1'b1, 2, 2, 15);
        idle();
        sum = 0;
        for (int k = 0; k < 16; k++) begin idle(); sum += int'(led[2]); end
        chk("pwm_duty15_high", sum, 15);
        step(1'b1, 1'b1, 2, 0, 0);

        // BLINK ch1 duty 1: toggles every 32 cycles
        step(1'b1, 1'b1, 1, 3, 1);
        prev = led[1];
        nt = 0;
        for (int k = 1; k <= 200 && nt < 3; k++) begin
            idle();
            if (led[1] !== prev) begin
                tt[nt] = k;
                nt++;
                prev = led[1];
            end
        end
        chk("blink_edges", nt, 3);
        if (nt == 3) begin
            chk("blink_half1", tt[1] - tt[0], 32);
            chk("blink_half2", tt[2] - tt[1], 32);
        end

        // write ch1 in a tick cycle: state cleared, tick discarded
        n = 0;
        while (tick !== 1'b1 && n < 40) begin idle(); n++; end
        chk("wait_tick", {31'd0, tick}, 32'd1);
        step(1'b1, 1'b1, 1, 3, 0);
        n = 0;
        do begin idle(); n++; end while (led[1] !== 1'b0 && n < 40);
        chk("tick_write_first_toggle", n, 17);

        // BREATHE ch0 peak 3: high-time per PWM period follows the level
        step(1'b1, 1'b1, 0, 4, 3);
        n = 0;
        while (tick !== 1'b1 && n < 40) begin idle(); n++; end
        chk("breathe_wait_tick", {31'd0, tick}, 32'd1);
        idle();
        for (int w = 0; w < 9; w++) begin
            sum = 0;
            for (int k = 0; k < 16; k++) begin idle(); sum += int'(led[0]); end
            chk($sformatf("breathe_win%0d", w), sum, exp_lv[w]);
        end

        // mid-operation reset
        step(1'b0, 1'b0, 0, 0, 0);
        chk("midrst_led", {29'd0, led}, 32'd2);
        chk("midrst_tick", {31'd0, tick}, 32'd0);
        for (int k = 0; k < 5; k++) idle();
        chk("midrst_modes_off", {29'd0, led}, 32'd2);

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 149) != 0, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
